updown_counter_presc: RTL and testbench
=======================================

Name: updown_counter_presc

Overview:
- Parametrised successor to the fixed 4-bit divided-clock down counter.
- Single clock domain: the internal prescaler issues a one-cycle enable strobe (`tick`) instead of generating a derived clock.
- Counter counts up or down, modulo MODULO, on each tick. It supports synchronous parallel load and a terminal-count pulse for cascading.
- Drives 7-segment/LED display logic and chains into further counter stages.

Parameters:
- WIDTH, 4, bit width of the count value `q`.
- MODULO, 16, number of count states (2..2**WIDTH); MAX = MODULO-1.
- DIV, 50000000, clk cycles per tick (>=1); DIV=1 means a tick every enabled cycle.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rs  in  1  synchronous active-high reset.
- en  in  1  count enable; gates both prescaler and counter.
- up_dn  in  1  1 = count up, 0 = count down; sampled at each tick.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value written on load.
- q  out  WIDTH  registered count value.
- tick  out  1  registered prescaler strobe, one clk cycle wide.
- tc  out  1  registered terminal-count pulse, one clk cycle wide.

Behaviour:
- Reset (rs=1 at the clk edge): q=0, prescaler=0, tick=0, tc=0. Reset has priority over all other inputs. Mid-count reset discards the partial prescale.
- Prescaler:
  - Counts 0..DIV-1 while en=1 and holds its value while en=0.
  - When it equals DIV-1 with en=1, it returns to 0 and the next-state strobe is raised.
  - `tick` is high in the cycle after that terminal prescale cycle, for exactly one cycle.
  - Tick period is DIV cycles with en held high. First tick after reset lands DIV cycles after rs deasserts.
- Count update (same edge that registers tick=1, i.e. q changes together with tick):
  - Up: q = (q==MAX) ? 0 : q+1.
  - Down: q = (q==0) ? MAX : q-1.
  - Arithmetic is WIDTH bits. The count never leaves 0..MAX, even when MODULO < 2**WIDTH.
- tc: high for one cycle, registered on the same edge as the wrap update:
  - up, MAX->0;
  - down, 0->MAX.
  - tc is 0 in every other cycle.
- Load:
  - load=1 sets q = (load_val > MAX) ? MAX : load_val. Out-of-range values saturate.
  - Load clears the prescaler to 0 and forces tick=0 and tc=0 that cycle.
  - Load has priority over a coincident tick; that tick is dropped, not deferred.
  - Load works regardless of en.
- Priority: rs > load > tick count > hold.
- en=0: q, prescaler and tc hold or stay low; tick=0. Re-enabling resumes from the held prescale value.
- Direction change takes effect at the next tick; there is no glitch and no skipped state.
- Latency: load -> q, 1 cycle. Prescaler terminal -> q/tick/tc, 1 cycle.

Decomposition:
- Shared package `counter_pkg`:
  - function clog2 for the prescaler width, clog2(DIV) with a minimum of 1;
  - localparam constants UP=1'b1, DN=1'b0.
- Sub-module `tick_gen` (params DIV; ports clk, rs, en, clr, tick). It replaces the old free-running clock divider and is reusable by other display blocks.
- Top level instantiates tick_gen and holds the count/tc register logic.

Test Plan (sim params WIDTH=4, MODULO=10, DIV=4):
- Reset, en=1, up_dn=0 -> first tick 4 cycles after rs drops, q 0->9 with tc=1 that cycle; then 8,7,...,0,9 at 4-cycle spacing with tc only on the 0->9 wraps.
- up_dn=1 from q=7 -> q 8,9,0 with tc=1 exactly on 9->0, and tick period = 4 cycles.
- load=1, load_val=13 while q=3 -> next cycle q=9 (saturated), tick=0, tc=0; next tick 4 cycles later.
- load coincident with a tick, load_val=5 -> q=5, no tick/tc that cycle, prescaler restarts from 0.
- en dropped for 10 cycles mid-prescale, then reasserted -> q frozen, tick=0, and the tick resumes after the remaining prescale cycles (total enabled cycles = 4).
- rs asserted mid-count with load=1 and a pending tick -> q=0, tick=0, tc=0 next cycle, and the prescaler restarts from 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled counter family.
package counter_pkg;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

    // Bits needed to hold 0..v-1; never less than one so a DIV=1 prescaler still has a register.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle enable strobe every DIV enabled clk cycles.
// The strobe is the next-state value (high during the terminal prescale cycle),
// so a consumer that registers it lines its own state update up with it.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rs,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = en && !clr && !rs && (r_cnt == LAST);
    assign tick   = w_last;

    // Prescale count: cleared by reset or clear, advances only while enabled.
    always_ff @(posedge clk) begin
        if (rs || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_presc.sv
// Modulo-MODULO up/down counter advanced by an internal prescaler strobe,
// with saturating parallel load and a terminal-count pulse for cascading.
module updown_counter_presc
    import counter_pkg::*;
#(
    parameter int          WIDTH  = 4,
    parameter int          MODULO = 16,
    parameter int unsigned DIV    = 50000000
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic             w_strobe;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_tc;

    // Load clears the prescaler so the next tick is a full period after the load.
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rs   (rs),
        .en   (en),
        .clr  (load),
        .tick (w_strobe)
    );

    assign w_load_sat = (load_val > MAX) ? MAX : load_val;

    // Count, tick and terminal-count registers; priority rs > load > tick > hold.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_q    <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_sat;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (w_strobe) begin
            r_tick <= 1'b1;
            if (up_dn == UP) begin
                r_q  <= (r_q == MAX) ? '0 : r_q + WIDTH'(1);
                r_tc <= (r_q == MAX);
            end else begin
                r_q  <= (r_q == '0) ? MAX : r_q - WIDTH'(1);
                r_tc <= (r_q == '0);
            end
        end else begin
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tick = r_tick;
    assign tc   = r_tc;

endmodule

// File: tb/tb_updown_counter_presc.sv
module tb_updown_counter_presc;

    localparam int WIDTH  = 4;
    localparam int MODULO = 10;
    localparam int DIV    = 4;
    localparam int MAXV   = MODULO - 1;

    logic             clk;
    logic             rs;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             tc;

    updown_counter_presc #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO),
        .DIV    (DIV)
    ) dut (
        .clk      (clk),
        .rs       (rs),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tick     (tick),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rs;
        bit en;
        bit up;
        bit ld;
        int lv;
        int q;
        bit tk;
        bit tc;
    } vec_t;

    typedef struct {
        int    q;
        bit    tk;
        bit    tc;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // behavioural reference state
    int m_pre = 0;
    int m_q   = 0;
    bit m_tk  = 0;
    bit m_tc  = 0;

    function automatic void model_step(bit r, bit e, bit u, bit l, int lv);
        if (r) begin
            m_pre = 0; m_q = 0; m_tk = 0; m_tc = 0;
        end else if (l) begin
            m_q = (lv > MAXV) ? MAXV : lv;
            m_pre = 0; m_tk = 0; m_tc = 0;
        end else if (e) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                m_tk  = 1;
                if (u) begin
                    m_tc = (m_q == MAXV);
                    m_q  = (m_q == MAXV) ? 0 : m_q + 1;
                end else begin
                    m_tc = (m_q == 0);
                    m_q  = (m_q == 0) ? MAXV : m_q - 1;
                end
            end else begin
                m_pre = m_pre + 1;
                m_tk  = 0;
                m_tc  = 0;
            end
        end else begin
            m_tk = 0;
            m_tc = 0;
        end
    endfunction

    task automatic check_out(string name);
        exp_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got q=%0d tick=%0b tc=%0b", name, q, tick, tc);
            return;
        end
        e = sbq.pop_front();
        if (q === WIDTH'(e.q) && tick === e.tk && tc === e.tc) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got q=%0d tick=%0b tc=%0b, want q=%0d tick=%0b tc=%0b",
                     e.name, q, tick, tc, e.q, e.tk, e.tc);
        end
    endtask

    // Drive one cycle; expected values either from the caller (use_exp) or from the model.
    task automatic drive(bit r, bit e, bit u, bit l, int lv, string name,
                         bit use_exp = 0, int xq = 0, bit xtk = 0, bit xtc = 0);
        exp_t x;
        rs = r; en = e; up_dn = u; load = l; load_val = WIDTH'(lv);
        model_step(r, e, u, l, lv);
        x.name = name;
        if (use_exp) begin
            x.q = xq; x.tk = xtk; x.tc = xtc;
        end else begin
            x.q = m_q; x.tk = m_tk; x.tc = m_tc;
        end
        sbq.push_back(x);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic step(bit r, bit e, bit u, bit l, int lv, string name);
        drive(r, e, u, l, lv, name);
    endtask

    task automatic expect_now(string name, int xq, bit xtk, bit xtc);
        n_checks++;
        if (q === WIDTH'(xq) && tick === xtk && tc === xtc) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got q=%0d tick=%0b tc=%0b, want q=%0d tick=%0b tc=%0b",
                     name, q, tick, tc, xq, xtk, xtc);
        end
    endtask

    vec_t vt[13];
    int   tc_seen;
    int   tick_seen;
    int   last_tick;

    initial begin
        rs = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;

        // reset, then count down: first tick 4 cycles after rs drops, 0 -> 9 with tc
        vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{0, 1, 0, 0, 0, 9, 1, 1};
        vt[5]  = '{0, 1, 0, 0, 0, 9, 0, 0};
        vt[6]  = '{0, 1, 0, 0, 0, 9, 0, 0};
        vt[7]  = '{0, 1, 0, 0, 0, 9, 0, 0};
        vt[8]  = '{0, 1, 0, 0, 0, 8, 1, 0};
        vt[9]  = '{0, 1, 0, 0, 0, 8, 0, 0};
        vt[10] = '{0, 1, 0, 0, 0, 8, 0, 0};
        vt[11] = '{0, 1, 0, 0, 0, 8, 0, 0};
        vt[12] = '{0, 1, 0, 0, 0, 7, 1, 0};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rs, vt[i].en, vt[i].up, vt[i].ld, vt[i].lv, $sformatf("vec%0d", i),
                  1, vt[i].q, vt[i].tk, vt[i].tc);
        end

        // keep counting down through the next 0 -> 9 wrap
        tc_seen = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0, 0, 0, "down_run");
            if (tc) tc_seen++;
        end
        expect_now("down_wrap_end", 9, 1, 1);
        n_checks++;
        if (tc_seen == 1) n_pass++;
        else $display("FAIL down_tc_count: got %0d, want 1", tc_seen);

        // up from 7: 8, 9, 0 with tc only on 9 -> 0, period 4
        step(0, 1, 1, 1, 7, "load7");
        expect_now("load7_q", 7, 0, 0);
        tc_seen = 0; tick_seen = 0; last_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 0, 0, "up_run");
            if (tick) begin
                tick_seen++;
                if (last_tick >= 0) begin
                    n_checks++;
                    if (i - last_tick == DIV) n_pass++;
                    else $display("FAIL tick_period: got %0d, want %0d", i - last_tick, DIV);
                end
                last_tick = i;
            end
            if (tc) tc_seen++;
        end
        expect_now("up_wrap_end", 0, 1, 1);
        n_checks++;
        if (tc_seen == 1 && tick_seen == 3) n_pass++;
        else $display("FAIL up_counts: got tc=%0d tick=%0d, want tc=1 tick=3", tc_seen, tick_seen);

        // saturating load of 13 while q=3
        step(0, 1, 1, 1, 3, "load3");
        step(0, 1, 0, 0, 0, "pre1");
        step(0, 1, 0, 1, 13, "load13");
        expect_now("load13_sat", 9, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "after_load13");
        expect_now("after_load13_quiet", 9, 0, 0);
        step(0, 1, 0, 0, 0, "after_load13_tick");
        expect_now("after_load13_tick_now", 8, 1, 0);

        // load coincident with a pending tick: tick dropped, prescaler restarts
        while (m_pre != DIV - 1) step(0, 1, 1, 0, 0, "to_terminal");
        step(0, 1, 1, 1, 5, "load_on_tick");
        expect_now("load_on_tick_q", 5, 0, 0);
        for (int i = 0; i < DIV; i++) step(0, 1, 1, 0, 0, "post_load_tick");
        expect_now("post_load_tick_now", 6, 1, 0);

        // en dropped for 10 cycles after 2 enabled prescale cycles
        step(0, 1, 1, 0, 0, "pre_a");
        step(0, 1, 1, 0, 0, "pre_b");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, "en_off");
        expect_now("en_off_frozen", 6, 0, 0);
        step(0, 1, 1, 0, 0, "resume_a");
        expect_now("resume_a_q", 6, 0, 0);
        step(0, 1, 1, 0, 0, "resume_b");
        expect_now("resume_b_tick", 7, 1, 0);

        // reset with load and a pending tick
        while (m_pre != DIV - 1) step(0, 1, 1, 0, 0, "to_terminal2");
        step(1, 1, 1, 1, 5, "rs_load_tick");
        expect_now("rs_priority", 0, 0, 0);
        for (int i = 0; i < DIV; i++) step(0, 1, 1, 0, 0, "post_rs");
        expect_now("post_rs_tick", 1, 1, 0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 15)), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
